manchester_serial_rx: RTL

Manchester serial receiver and decoder. Recovers bytes from a single-wire Manchester half-bit stream and presents each byte on a valid/ready output port. It is the receive end of the team's Manchester serial link:
- Frame: idle-low line, a two-half-bit start symbol, then 8 Manchester-coded data bits, MSB first.
- Coding: bit 1 = half-bits 0,1; bit 0 = half-bits 1,0.
- Sits between the link pin (or a loopback from the transmitter) and the byte-consuming logic.

---
 rtl/manchester_pkg.sv | 15 +
 rtl/manchester_pair_decoder.sv | 20 ++
 rtl/manchester_serial_rx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/manchester_pkg.sv
// Shared constants for the Manchester serial link: half-bit pair codes, start symbol and
// receiver FSM state encodings.
package manchester_pkg;

    localparam logic [1:0] HB_ONE    = 2'b01;
    localparam logic [1:0] HB_ZERO   = 2'b10;
    localparam logic [1:0] START_SYM = 2'b11;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StArmed  = 3'd1;
    localparam logic [2:0] StStart  = 3'd2;
    localparam logic [2:0] StFirst  = 3'd3;
    localparam logic [2:0] StSecond = 3'd4;

endpackage

// File: rtl/manchester_pair_decoder.sv
// Decodes one Manchester half-bit pair {first, second} into a data bit; 00 and 11 are illegal.
module manchester_pair_decoder
    import manchester_pkg::*;
(
    input  logic [1:0] pair_i,
    output logic       bit_o,
    output logic       err_o
);

    always_comb begin
        bit_o = 1'b0;
        err_o = 1'b0;
        unique case (pair_i)
            HB_ONE:  bit_o = 1'b1;
            HB_ZERO: bit_o = 1'b0;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/manchester_serial_rx.sv
// Manchester serial receiver: locks to the start edge, samples mid half-bit, decodes MSB-first
// data bits and delivers each byte through a single valid/ready holding register.
module manchester_serial_rx
    import manchester_pkg::*;
#(
    parameter int unsigned HALF_BIT_CLKS = 1,
    parameter int unsigned DATA_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              code_err,
    output logic              overrun
);

    localparam int unsigned CntW = $clog2(HALF_BIT_CLKS + 1);
    localparam int unsigned BitW = $clog2(DATA_W + 1);
    localparam int unsigned EdgeOffs = HALF_BIT_CLKS / 2;
    localparam logic [CntW-1:0] HalfReload = CntW'(HALF_BIT_CLKS - 1);
    localparam logic [CntW-1:0] EdgeReload = CntW'((EdgeOffs > 0) ? EdgeOffs - 1 : 0);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

    logic              s_q;
    logic [2:0]        state_q, state_d;
    logic              locked_q, locked_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_next;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              code_err_q, code_err_d;
    logic              overrun_q, overrun_d;

    logic              tick;
    logic              dec_bit, dec_err;
    logic              frame_done;
    logic [DATA_W-1:0] done_data;

    manchester_pair_decoder u_pair_decoder (
        .pair_i ({first_q, s_q}),
        .bit_o  (dec_bit),
        .err_o  (dec_err)
    );

    assign tick      = (cnt_q == '0);
    assign cnt_next  = tick ? HalfReload : cnt_q - 1'b1;
    assign done_data = {shift_q[DATA_W-2:0], dec_bit};

    always_comb begin
        state_d    = state_q;
        locked_d   = locked_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        first_d    = first_q;
        code_err_d = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            StIdle: begin
                locked_d = 1'b0;
                if (!s_q) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // locked_q marks that the start edge was seen and the offset count is running
                if (!locked_q) begin
                    if (s_q) begin
                        if (EdgeOffs == 0) begin
                            state_d = StStart;
                            cnt_d   = HalfReload;
                        end else begin
                            locked_d = 1'b1;
                            cnt_d    = EdgeReload;
                        end
                    end
                end else begin
                    cnt_d = cnt_next;
                    if (tick) begin
                        locked_d = 1'b0;
                        state_d  = s_q ? StStart : StIdle;
                    end
                end
            end
            StStart: begin
                cnt_d = cnt_next;
                if (tick) begin
                    if ({1'b1, s_q} == START_SYM) begin
                        state_d   = StFirst;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StFirst: begin
                cnt_d = cnt_next;
                if (tick) begin
                    first_d = s_q;
                    state_d = StSecond;
                end
            end
            StSecond: begin
                cnt_d = cnt_next;
                if (tick) begin
                    if (dec_err) begin
                        code_err_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        shift_d   = done_data;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            frame_done = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            state_d = StFirst;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        // A handshake in the completion cycle frees the register, so that is not an overrun
        if (frame_done) begin
            if (!valid_q || ready) begin
                data_d  = done_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q        <= 1'b0;
            state_q    <= StIdle;
            locked_q   <= 1'b0;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            first_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            s_q        <= serial_in;
            state_q    <= state_d;
            locked_q   <= locked_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            first_q    <= first_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            code_err_q <= code_err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign code_err = code_err_q;
    assign overrun  = overrun_q;

endmodule
